// File: rtl/vec_mul_seq_pkg.sv
// Shared types and default geometry for the vector-multiply sequencer.
package vec_mul_pkg;

  localparam int N_DEF         = 8;
  localparam int DATA_BW_DEF   = 8;
  localparam int PSUM_BW_DEF   = 20;
  localparam int ADDR_W_DEF    = 10;
  localparam int W_ADDR_W_DEF  = 2;
  localparam int ARRAY_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_WAIT_W = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_FIN    = 3'd5
  } state_e;

endpackage

// File: rtl/vec_mul_seq_valid_delay.sv
// Fixed-depth shift register for a valid bit; clr empties it on the next edge.
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = (sr_q << 1) | DEPTH'(valid_i);
    if (clr) sr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign valid_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vec_mul_seq.sv
// Job sequencer for the vector-multiply array: optional weight load, UB
// streaming and result write-back, with abort and start/busy/done handshake.
module vec_mul_seq
  import vec_mul_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DATA_BW   = DATA_BW_DEF,
  parameter int PSUM_BW   = PSUM_BW_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int W_ADDR_W  = W_ADDR_W_DEF,
  parameter int ARRAY_LAT = ARRAY_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      cfg_src_base,
  input  logic [ADDR_W-1:0]      cfg_dst_base,
  input  logic [ADDR_W-1:0]      cfg_len,
  input  logic [W_ADDR_W-1:0]    cfg_w_addr,
  input  logic                   cfg_reload,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ub_rd_en,
  output logic [ADDR_W-1:0]      ub_rd_addr,
  output logic                   wgt_rd_en,
  output logic [W_ADDR_W-1:0]    wgt_rd_addr,
  output logic                   arr_weight_load,
  output logic                   arr_data_valid,
  input  logic [PSUM_BW*N-1:0]   arr_result,
  output logic                   res_wr_en,
  output logic [ADDR_W-1:0]      res_wr_addr,
  output logic [PSUM_BW*N-1:0]   res_wr_data,
  output logic [2:0]             dbg_state_o
);

  if (N < 1 || DATA_BW < 1 || ARRAY_LAT < 1) begin : g_bad_param
    $error("vec_mul_seq: N, DATA_BW and ARRAY_LAT must be >= 1");
  end

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     src_q, dst_q, len_q, rd_idx_q, wr_idx_q;
  logic [W_ADDR_W-1:0]   wbase_q;
  logic                  adv_q;
  logic                  cfg_load, abort_clr, res_valid;
  logic [ADDR_W-1:0]     last_idx;

  assign abort_clr = abort && (state_q != S_IDLE);
  assign last_idx  = len_q - ADDR_W'(1);

  // Handshake: start is sampled only in IDLE; busy is high from the cycle
  // after acceptance through the done cycle; abort outside IDLE drops the job
  // (no done, no further writes). There is no back-pressure anywhere.
  always_comb begin
    state_d         = state_q;
    cfg_load        = 1'b0;
    wgt_rd_en       = 1'b0;
    arr_weight_load = 1'b0;
    ub_rd_en        = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_load = 1'b1;
          if (cfg_len == '0)   state_d = S_FIN;
          else if (cfg_reload) state_d = S_LOAD_W;
          else                 state_d = S_STREAM;
        end
      end
      S_LOAD_W: begin
        wgt_rd_en = 1'b1;
        state_d   = S_WAIT_W;
      end
      S_WAIT_W: begin
        arr_weight_load = 1'b1;
        state_d         = S_STREAM;
      end
      S_STREAM: begin
        ub_rd_en = 1'b1;
        if (rd_idx_q == last_idx) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The last write retiring means the valid pipeline is now empty.
        if (res_valid && wr_idx_q == last_idx) state_d = S_FIN;
      end
      S_FIN: begin
        done    = !abort;
        err     = !abort && (len_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_clr) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      wbase_q  <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      adv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      adv_q   <= ub_rd_en && !abort_clr;
      if (cfg_load) begin
        src_q    <= cfg_src_base;
        dst_q    <= cfg_dst_base;
        len_q    <= cfg_len;
        wbase_q  <= cfg_w_addr;
        rd_idx_q <= '0;
        wr_idx_q <= '0;
      end else begin
        if (ub_rd_en)  rd_idx_q <= rd_idx_q + ADDR_W'(1);
        if (res_valid) wr_idx_q <= wr_idx_q + ADDR_W'(1);
      end
    end
  end

  valid_delay #(.DEPTH(ARRAY_LAT)) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (abort_clr),
    .valid_i (adv_q),
    .valid_o (res_valid)
  );

  assign busy           = (state_q != S_IDLE);
  assign arr_data_valid = adv_q;
  assign ub_rd_addr     = ub_rd_en  ? src_q + rd_idx_q : '0;
  assign wgt_rd_addr    = wgt_rd_en ? wbase_q : '0;
  assign res_wr_en      = res_valid && !abort_clr;
  assign res_wr_addr    = res_wr_en ? dst_q + wr_idx_q : '0;
  assign res_wr_data    = res_wr_en ? arr_result : '0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_vec_mul_seq.sv
// Scoreboard bench for vec_mul_seq: drivers push timed expected events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vec_mul_seq;

  localparam int N         = 8;
  localparam int DATA_BW   = 8;
  localparam int PSUM_BW   = 20;
  localparam int ADDR_W    = 10;
  localparam int W_ADDR_W  = 2;
  localparam int ARRAY_LAT = 2;
  localparam int DW        = PSUM_BW * N;
  localparam int RD_W      = 16 + ADDR_W;
  localparam int WR_W      = 16 + ADDR_W + DW;
  localparam int WG_W      = 16 + 1 + W_ADDR_W;
  localparam int DN_W      = 16 + 2;

  logic                clk, rst, start, abort, cfg_reload;
  logic [ADDR_W-1:0]   cfg_src_base, cfg_dst_base, cfg_len;
  logic [W_ADDR_W-1:0] cfg_w_addr;
  logic                busy, done, err, ub_rd_en, wgt_rd_en, arr_weight_load, arr_data_valid, res_wr_en;
  logic [ADDR_W-1:0]   ub_rd_addr, res_wr_addr;
  logic [W_ADDR_W-1:0] wgt_rd_addr;
  logic [DW-1:0]       arr_result, res_wr_data;
  logic [2:0]          dbg_state;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [RD_W-1:0] rd_q[$];
  logic [WR_W-1:0] wr_q[$];
  logic [WG_W-1:0] wg_q[$];
  logic [DN_W-1:0] dn_q[$];
  bit              busy_exp [0:2047];
  logic [15:0]     s;

  vec_mul_seq #(
    .N(N), .DATA_BW(DATA_BW), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W),
    .W_ADDR_W(W_ADDR_W), .ARRAY_LAT(ARRAY_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_len(cfg_len),
    .cfg_w_addr(cfg_w_addr), .cfg_reload(cfg_reload),
    .busy(busy), .done(done), .err(err),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
    .arr_weight_load(arr_weight_load), .arr_data_valid(arr_data_valid),
    .arr_result(arr_result),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .dbg_state_o(dbg_state)
  );

  // clock / reset-independent cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // array model output: a per-cycle, per-lane distinct pattern
  function automatic logic [DW-1:0] pat(input int x);
    logic [DW-1:0] p;
    for (int j = 0; j < N; j++) p[j*PSUM_BW +: PSUM_BW] = PSUM_BW'(x * 37 + j * 5 + 3);
    return p;
  endfunction

  assign arr_result = pat(cyc);

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (stamp %0d)", name, got, want, cyc + 1);
    end
  endtask

  task automatic unexpected(input string name, input logic [255:0] got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with no expected entry", name, got);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected events of one job accepted at edge t; only stamps < cut are pushed.
  task automatic push_job(input bit r, input int len, input logic [ADDR_W-1:0] src,
                          input logic [ADDR_W-1:0] dst, input logic [W_ADDR_W-1:0] wa,
                          input int t, input int cut);
    int off, st, sd;
    off = r ? 0 : 2;
    if (len == 0) begin
      if (t + 1 < cut) begin
        dn_q.push_back({16'(t + 1), 2'b11});
        busy_exp[t + 1] = 1'b1;
      end
      return;
    end
    if (r && t + 1 < cut) wg_q.push_back({16'(t + 1), 1'b0, wa});
    if (r && t + 2 < cut) wg_q.push_back({16'(t + 2), 1'b1, W_ADDR_W'(0)});
    for (int i = 0; i < len; i++) begin
      st = t + 3 - off + i;
      if (st < cut) rd_q.push_back({16'(st), ADDR_W'(src + ADDR_W'(i))});
    end
    for (int k = 0; k < len; k++) begin
      st = t + 4 + ARRAY_LAT - off + k;
      if (st < cut) wr_q.push_back({16'(st), ADDR_W'(dst + ADDR_W'(k)), pat(st - 1)});
    end
    sd = t + 4 + ARRAY_LAT + len - off;
    if (sd < cut) dn_q.push_back({16'(sd), 2'b10});
    for (int c = t + 1; c <= sd; c++) if (c < cut) busy_exp[c] = 1'b1;
  endtask

  task automatic start_job(input bit r, input int len, input logic [ADDR_W-1:0] src,
                           input logic [ADDR_W-1:0] dst, input logic [W_ADDR_W-1:0] wa,
                           input int cut_rel, output int t);
    cfg_reload   = r;
    cfg_len      = ADDR_W'(len);
    cfg_src_base = src;
    cfg_dst_base = dst;
    cfg_w_addr   = wa;
    start        = 1'b1;
    t            = cyc + 1;
    push_job(r, len, src, dst, wa, t, t + cut_rel);
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check(name, {busy, done, err, ub_rd_en, ub_rd_addr, wgt_rd_en, wgt_rd_addr, arr_weight_load,
                 arr_data_valid, res_wr_en, res_wr_addr, dbg_state}, '0);
    check({name, "_data"}, res_wr_data, '0);
  endtask

  // monitor: pops the matching queue whenever the DUT presents an event
  always @(negedge clk) begin
    logic [RD_W-1:0] er;
    logic [WR_W-1:0] ew;
    logic [WG_W-1:0] eg;
    logic [DN_W-1:0] ed;
    if (!rst) begin
      s = 16'(cyc + 1);
      check("busy", busy, busy_exp[s]);
      if (ub_rd_en) begin
        if (rd_q.size() == 0) unexpected("ub_rd", {s, ub_rd_addr});
        else begin er = rd_q.pop_front(); check("ub_rd", {s, ub_rd_addr}, er); end
      end
      if (wgt_rd_en) begin
        if (wg_q.size() == 0) unexpected("wgt_rd", {s, wgt_rd_addr});
        else begin eg = wg_q.pop_front(); check("wgt_rd", {s, 1'b0, wgt_rd_addr}, eg); end
      end
      if (arr_weight_load) begin
        if (wg_q.size() == 0) unexpected("wgt_load", {s});
        else begin eg = wg_q.pop_front(); check("wgt_load", {s, 1'b1, W_ADDR_W'(0)}, eg); end
      end
      if (res_wr_en) begin
        if (wr_q.size() == 0) unexpected("res_wr", {s, res_wr_addr});
        else begin ew = wr_q.pop_front(); check("res_wr", {s, res_wr_addr, res_wr_data}, ew); end
      end
      if (done || err) begin
        if (dn_q.size() == 0) unexpected("done", {s, done, err});
        else begin ed = dn_q.pop_front(); check("done", {s, done, err}, ed); end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_reload = 1'b0;
    cfg_src_base = '0; cfg_dst_base = '0; cfg_len = '0; cfg_w_addr = '0;
    tick(3);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    tick(2);

    // reload, L=3: reads 0x10..0x12 at T+3..T+5, writes 0x20..0x22 at T+6..T+8, done T+9
    start_job(1'b1, 3, 10'h010, 10'h020, 2'd1, 1000, t);
    tick(12);
    // reuse weights, L=1: single write at T+4, done T+5
    start_job(1'b0, 1, 10'h040, 10'h050, 2'd0, 1000, t);
    tick(8);
    // address wrap on both sides
    start_job(1'b0, 3, 10'h3FE, 10'h3FF, 2'd0, 1000, t);
    tick(10);
    // empty job: done and err at T+1
    start_job(1'b0, 0, 10'h077, 10'h088, 2'd0, 1000, t);
    tick(4);

    // start held high: ignored during the job and in FIN, accepted the cycle after
    cfg_reload = 1'b0; cfg_len = 10'd2; cfg_src_base = 10'h200; cfg_dst_base = 10'h210; cfg_w_addr = 2'd0;
    start = 1'b1;
    t = cyc + 1;
    push_job(1'b0, 2, 10'h200, 10'h210, 2'd0, t, t + 1000);
    push_job(1'b0, 2, 10'h200, 10'h210, 2'd0, t + 7, t + 1000);
    tick(8);
    start = 1'b0;
    tick(10);

    // L=8 with reload; stray start at T+4, abort at T+5
    start_job(1'b1, 8, 10'h100, 10'h180, 2'd2, 6, t);
    tick(3);
    cfg_len = 10'd0; cfg_reload = 1'b0; cfg_src_base = 10'h003; start = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(12);

    // reset in the middle of STREAM, then a normal job
    start_job(1'b0, 4, 10'h300, 10'h310, 2'd0, 3, t);
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid");
    @(posedge clk); #1 rst = 1'b0;
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    start_job(1'b1, 2, 10'h020, 10'h030, 2'd3, 1000, t);
    tick(12);

    check("rd_left", 256'(rd_q.size()), '0);
    check("wr_left", 256'(wr_q.size()), '0);
    check("wgt_left", 256'(wg_q.size()), '0);
    check("done_left", 256'(dn_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mul_seq.md
# vec_mul_seq

Parametrised sequencer and datapath glue for the vector-multiply engine: on one `start` it optionally loads an NxN weight tile from the weight SRAM into the array, streams `cfg_len` input vectors from the Unified Buffer through the array, and writes each PSUM result vector to the result SRAM at consecutive addresses. It replaces fixed 8x8, hard-wired result addressing with configurable size, base addresses, job length, weight reuse, abort and a start/busy/done handshake. It sits between the SRAM macros and the array, driving their enables and addresses.

## Interface
- `N`, 8, array dimension (vector length, PE rows/cols)
- `DATA_BW`, 8, input element width
- `PSUM_BW`, 20, result element width
- `ADDR_W`, 10, UB and result SRAM address width
- `W_ADDR_W`, 2, weight SRAM address width
- `ARRAY_LAT`, 2, cycles from `arr_data_valid` to matching `arr_result` valid (>=1)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  job request, sampled in IDLE only
- `abort`  in  1  cancel current job
- `cfg_src_base`  in  ADDR_W  first UB read address
- `cfg_dst_base`  in  ADDR_W  first result write address
- `cfg_len`  in  ADDR_W  number of vectors in job
- `cfg_w_addr`  in  W_ADDR_W  weight tile address
- `cfg_reload`  in  1  1 = load weights, 0 = reuse current weights
- `busy`  out  1  high from cycle after accepted start until done cycle inclusive
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `done` when `cfg_len`==0
- `ub_rd_en` / `ub_rd_addr`  out  1 / ADDR_W  UB read (sync SRAM, 1-cycle latency)
- `wgt_rd_en` / `wgt_rd_addr`  out  1 / W_ADDR_W  weight SRAM read (1-cycle latency)
- `arr_weight_load`  out  1  array latches weight bus this cycle
- `arr_data_valid`  out  1  UB data on array input is valid
- `arr_result`  in  PSUM_BW*N  array output
- `res_wr_en` / `res_wr_addr` / `res_wr_data`  out  1 / ADDR_W / PSUM_BW*N  result SRAM write

## Operation
- States: IDLE, LOAD_W, WAIT_W, STREAM, DRAIN, FIN.
- IDLE: `start`=1 registers all `cfg_*`; `cfg_len`==0 -> FIN with err; else `cfg_reload` ? LOAD_W : STREAM. `start` outside IDLE ignored.
- LOAD_W: `wgt_rd_en`=1, addr=`cfg_w_addr`; -> WAIT_W. WAIT_W: `arr_weight_load`=1 for one cycle; -> STREAM.
- STREAM: `ub_rd_en`=1 for exactly `cfg_len` consecutive cycles, addr = src_base + i (i=0..len-1), wraps mod 2^ADDR_W; -> DRAIN after last issue.
- `arr_data_valid` = `ub_rd_en` delayed 1 cycle. Result valid = `arr_data_valid` delayed ARRAY_LAT cycles; on it `res_wr_en`=1, `res_wr_data`=`arr_result`, `res_wr_addr` = dst_base + k (k=0..len-1), wrapping.
- DRAIN: wait until valid pipeline empty; -> FIN. FIN: `done`=1 (and `err` if len==0), -> IDLE. `start` in FIN ignored; may be accepted next cycle.
- `abort` (any non-IDLE state): -> IDLE next cycle, valid pipeline cleared, no further `res_wr_en`, no `done`. Abort in IDLE: no effect.
- Weights persist across jobs; `cfg_reload`=0 after reset uses whatever the array holds (no check).

## Timing
- Reset: state IDLE; all outputs 0; counters and delay line cleared. Reset mid-job drops in-flight writes.
- Start accepted at edge T (cfg_reload=1, len=L): `wgt_rd_en` T+1, `arr_weight_load` T+2, `ub_rd_en` T+3..T+2+L, `res_wr_en` T+4+ARRAY_LAT..T+3+ARRAY_LAT+L, `done` T+4+ARRAY_LAT+L. With cfg_reload=0 all subtract 2.
- len==0: `done`,`err` at T+1.
- Max throughput one vector per cycle; no back-pressure.

## Structure
- Package `vec_mul_pkg`: state enum, default widths (N, DATA_BW, PSUM_BW, ADDR_W).
- Sub-module `valid_delay`: parametrised depth shift register carrying valid bit, synchronous clear for abort; result-address counter advances on its output.

## Test plan
- Reset mid-STREAM with N=8, L=4 -> all outputs 0 next cycle; subsequent job runs normally.
- cfg_reload=1, L=3, src=0x10, dst=0x20, ARRAY_LAT=2 -> UB reads 0x10-0x12 at T+3..T+5, writes 0x20-0x22 at T+6..T+8, done T+9, busy T+1..T+9.
- cfg_reload=0, L=1 -> no wgt_rd_en/arr_weight_load; single write at T+4, done T+5.
- Wrap: src=0x3FE, dst=0x3FF, L=3 -> reads 0x3FE,0x3FF,0x000; writes 0x3FF,0x000,0x001.
- L=0 -> done and err at T+1, no reads/writes; start during busy ignored, abort at T+5 of L=8 -> no done, no writes after abort.
